ps2_scan_receiver: RTL

- Upstream stage of the keyboard interrupt block.
- Deserialises the PS/2 clock/data line pair into scan-code bytes.
- Tracks E0 (extended) and F0 (break) prefixes.
- Presents the held key as an active-low keyDown level plus a 16-bit inputValue, which the keyboard block forwards as interrupt and data.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_frame_rx.sv | 159 +++++++++++++++
 rtl/ps2_scan_receiver.sv | 79 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM encoding for the PS/2 scan-code receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: sync, ps2Clk glitch filter, start/8 data/parity/stop FSM, timeout.
// Latency: byteValid one clk after the stop-bit sample edge; sample edge FILTER_LEN+2 clk after raw fall.
// Backpressure: none; the PS/2 device cannot be stalled, byteValid is a single-cycle pulse.
// Option: PS2_PARITY_CHECK_EN enables odd-parity checking (default build ignores parity bit).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameError,
    output logic       frameTimeout
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(PS2_DATA_BITS - 1);

    logic          clkMeta, clkSync, datMeta, datSync;
    logic          clkFilt;
    logic [FW-1:0] filtCnt;
    logic [TW-1:0] tmoCnt;
    logic          sampleEdge, timeoutHit, parityOk;

    ps2_state_t    state, stateNext;
    logic [2:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftRegNext;
    logic          parBit, parBitNext;
    logic          validNext, errNext;

    // Two-flop synchronisers; idle line level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkMeta <= 1'b1;
            clkSync <= 1'b1;
            datMeta <= 1'b1;
            datSync <= 1'b1;
        end else begin
            clkMeta <= ps2Clk;
            clkSync <= clkMeta;
            datMeta <= ps2Data;
            datSync <= datMeta;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkFilt <= 1'b1;
            filtCnt <= '0;
        end else if (clkSync != clkFilt) begin
            if (filtCnt == FILT_LAST) begin
                clkFilt <= clkSync;
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end else begin
            filtCnt <= '0;
        end
    end

    // The cycle in which the filtered clock is about to fall is the bit sample point.
    assign sampleEdge = clkFilt & ~clkSync & (filtCnt == FILT_LAST);

    // Inactivity counter: restarts on every sample edge and is held clear while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmoCnt <= '0;
        end else if (state == IDLE || sampleEdge) begin
            tmoCnt <= '0;
        end else begin
            tmoCnt <= tmoCnt + 1'b1;
        end
    end

    assign timeoutHit = (state != IDLE) && !sampleEdge && (tmoCnt == TMO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign parityOk = ^{shiftReg, parBit};
`else
    assign parityOk = 1'b1;
`endif

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bitCnt       <= '0;
            shiftReg     <= '0;
            parBit       <= 1'b0;
            byteValid    <= 1'b0;
            frameError   <= 1'b0;
            frameTimeout <= 1'b0;
        end else begin
            state        <= stateNext;
            bitCnt       <= bitCntNext;
            shiftReg     <= shiftRegNext;
            parBit       <= parBitNext;
            byteValid    <= validNext;
            frameError   <= errNext;
            frameTimeout <= timeoutHit;
        end
    end

    // Next-state logic: start bit, LSB-first data, parity capture, stop check.
    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        parBitNext   = parBit;
        validNext    = 1'b0;
        errNext      = 1'b0;
        if (timeoutHit) begin
            stateNext = IDLE;
            errNext   = 1'b1;
        end else if (sampleEdge) begin
            case (state)
                IDLE: begin
                    if (!datSync) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                    end
                end
                DATA: begin
                    shiftRegNext = {datSync, shiftReg[7:1]};
                    bitCntNext   = bitCnt + 1'b1;
                    if (bitCnt == BIT_LAST) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parBitNext = datSync;
                    stateNext  = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (datSync && parityOk) begin
                        validNext = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign rxByte = shiftReg;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 scan-code receiver: frames bytes, tracks E0/F0 prefixes, holds active-low keyDown and inputValue.
// Latency: outputs update 2 clk after the stop-bit sample edge.
// Backpressure: none; scanStrobe and frameError are single-cycle pulses.
// Option: PS2_PARITY_CHECK_EN (see ps2_frame_rx) rejects frames with bad odd parity.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    output logic        keyDown,
    output logic [15:0] inputValue,
    output logic        scanStrobe,
    output logic        frameError
);

    logic        byteValid;
    logic [7:0]  rxByte;
    logic        frameTimeout;
    logic        extFlag, brkFlag;
    logic [15:0] codeValue;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2Clk       (ps2Clk),
        .ps2Data      (ps2Data),
        .byteValid    (byteValid),
        .rxByte       (rxByte),
        .frameError   (frameError),
        .frameTimeout (frameTimeout)
    );

    assign codeValue = {(extFlag ? PS2_EXT_CODE : 8'h00), rxByte};

    // Prefix tracking and make/break decode into the held-key outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyDown    <= 1'b1;
            inputValue <= 16'h0000;
            scanStrobe <= 1'b0;
            extFlag    <= 1'b0;
            brkFlag    <= 1'b0;
        end else begin
            scanStrobe <= 1'b0;
            if (byteValid) begin
                case (rxByte)
                    PS2_EXT_CODE:   extFlag <= 1'b1;
                    PS2_BRK_CODE:   brkFlag <= 1'b1;
                    PS2_PAUSE_CODE: ;
                    default: begin
                        if (!brkFlag) begin
                            inputValue <= codeValue;
                            keyDown    <= 1'b0;
                        end else if (codeValue == inputValue && !keyDown) begin
                            // Only the break of the most recently made key releases it.
                            keyDown <= 1'b1;
                        end
                        scanStrobe <= 1'b1;
                        extFlag    <= 1'b0;
                        brkFlag    <= 1'b0;
                    end
                endcase
            end else if (frameTimeout) begin
                // An aborted frame may have split a prefixed sequence; start clean.
                extFlag <= 1'b0;
                brkFlag <= 1'b0;
            end
        end
    end

endmodule
